fpu_normround: RTL and testbench
================================

Name: fpu_normround

Overview:
- Post-add stage of the single-precision FPU add/sub datapath. Sits directly downstream of the mantissa adder and complement logic.
- Takes the raw signed-magnitude sum with guard/round/sticky bits, normalises it with a 1-bit-per-cycle shifter, rounds to nearest-even and packs the IEEE-754 result.
- Uses a valid/ready handshake on both sides, so the adder stage can stall.

Parameters:
- S, 1, sign width
- E, 8, exponent width
- M, 23, stored mantissa width

Ports:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  upstream sum valid
- in_ready  output  1  stage can accept; equals (state==IDLE)
- in_sign  input  1  sign of sum magnitude
- in_exp  input  E  exponent of larger operand (biased)
- in_mant  input  M+5  [M+4]=carry, [M+3]=hidden, [M+2:3]=fraction, [2]=G, [1]=R, [0]=sticky
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- result  output  S+E+M  packed {sign, exp, frac}
- ovf  output  1  result overflowed to infinity
- uflow  output  1  result flushed to zero

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, ovf=0, uflow=0. Working registers are cleared. A reset mid-operation discards the operation and produces no output.
- Internal exponent is E+2 bits signed, so overflow and underflow are detectable.
- Clock and reset are fixed: one clock; reset is asynchronous and active-low.
- States: IDLE, NORM, ROUND, DONE.
- IDLE: accept on in_valid & in_ready. Capture the inputs, then branch on the first matching condition:
  - in_mant==0 → result={0,0,0} (exact zero is forced +0), uflow=0 → DONE.
  - in_exp==0 → flush: result={in_sign,0,0}, uflow=1 → DONE.
  - in_exp==all ones → result={in_sign,all ones,0}, ovf=0 → DONE.
  - carry=1 → shift right 1, with new bit0 = old bit1 | old bit0; exp+1 → ROUND.
  - hidden=1 → ROUND.
  - otherwise → NORM.
- NORM: each cycle, shift left 1 (zero fill) and exp-1.
  - Exit to ROUND in the cycle the hidden bit becomes 1.
  - If exp==1 and hidden is still 0 before the shift: result={in_sign,0,0}, uflow=1 → DONE.
  - Maximum M+3 iterations.
- ROUND (1 cycle): inc = G & (R | sticky | frac[0]). Compute {hidden,frac}+inc.
  - On carry-out: frac=0, exp+1.
  - If final exp ≥ all ones: result={sign,all ones,0}, ovf=1.
  - Otherwise pack {sign, exp[E-1:0], frac}.
  - → DONE.
- DONE: out_valid=1. result, ovf and uflow are stable while out_valid & !out_ready. On out_ready → IDLE, out_valid=0 next cycle. in_ready reasserts in the same cycle the state returns to IDLE; there is no accept in the DONE cycle.
- ovf and uflow are valid only with out_valid and are cleared on each new accept.
- Latency, counted from the accept edge to out_valid high:
  - special cases / zero: 1 cycle
  - carry or already-normalised: 2 cycles
  - k-shift normalisation: 2+k cycles
- Throughput: one operation in flight. A new accept requires a return to IDLE.

Test Plan:
- in_sign=0, in_exp=127, in_mant=1<<27 (1.0+1.0) → result=0x40000000 two cycles after accept, ovf=0.
- in_exp=130, in_mant=1<<24 (two-bit cancellation) → two NORM cycles, result=0x40000000 four cycles after accept.
- Round tie:
  - in_exp=127, in_mant={carry 0, hidden 1, frac all ones, G=1, R=0, S=0} → rounds up with carry, result=0x40000000.
  - Same with frac=0 → stays even, result=0x3F800000.
- in_exp=254, in_mant=1<<27, in_sign=1 → result=0xFF800000, ovf=1.
- Cancellation / underflow:
  - in_mant=0, in_sign=1 → result=0x00000000 one cycle after accept.
  - in_exp=3, in_mant=1<<20 → uflow=1, result=0x00000000.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE → result stable and in_ready=0 throughout; out_ready=1 → IDLE, then the next operand is accepted.
  - Pulse rst_n low during NORM → outputs zero immediately and out_valid never rises for that operand.

Source files
------------

// File: rtl/fpu_normround.sv
// fpu_normround: normalise, round-to-nearest-even and pack the FPU adder's raw sum
//   clk, rst_n               : clock, asynchronous active-low reset
//   in_valid/in_ready        : upstream handshake; in_ready is high only in IDLE
//   in_sign/in_exp/in_mant   : sum magnitude {carry, hidden, frac, G, R, sticky}
//   out_valid/out_ready      : downstream handshake; result held while stalled
//   result/ovf/uflow         : packed {sign, exp, frac}, overflow and flush flags
module fpu_normround #(
  parameter int S = 1,
  parameter int E = 8,
  parameter int M = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [E-1:0]     in_exp,
  input  logic [M+4:0]     in_mant,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [S+E+M-1:0] result,
  output logic             ovf,
  output logic             uflow
);
  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
  state_t state, state_nx;
  logic sign_q;
  logic signed [E+1:0] exp_q, rexp;
  logic [M+3:0] mant_q;
  logic [M-1:0] rfrac;
  logic accept, special, flush, inc, rcarry, rovf;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    accept = in_valid & in_ready;
    special = in_mant == '0 || in_exp == '0 || &in_exp;
    // hidden bit is always 0 in NORM, so reaching exp 1 means the value is subnormal
    flush = exp_q == (E+2)'(1) && !mant_q[M+3];
    inc = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
    // all-ones significand plus increment wraps the fraction to zero and bumps the exponent
    rcarry = &mant_q[M+3:3] & inc;
    rfrac = mant_q[M+2:3] + M'(inc);
    rexp = exp_q + (E+2)'(rcarry);
    rovf = rexp >= (E+2)'({E{1'b1}});
    state_nx = state == IDLE  ? (accept ? (special ? DONE : |in_mant[M+4:M+3] ? ROUND : NORM) : IDLE)
             : state == NORM  ? (flush ? DONE : mant_q[M+2] ? ROUND : NORM)
             : state == ROUND ? DONE
             : (out_ready ? IDLE : DONE);
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sign_q <= 1'b0;
      exp_q <= '0;
      mant_q <= '0;
      result <= '0;
      ovf <= 1'b0;
      uflow <= 1'b0;
    end else if (accept) begin
      sign_q <= in_sign;
      ovf <= 1'b0;
      uflow <= in_mant != '0 && in_exp == '0;
      exp_q <= (E+2)'(in_exp) + (E+2)'(in_mant[M+4]);
      // carry-out: shift right, folding the dropped bit into sticky
      mant_q <= in_mant[M+4] ? {in_mant[M+4:2], |in_mant[1:0]} : in_mant[M+3:0];
      // only meaningful for the special cases; other paths overwrite it before DONE
      result <= in_mant == '0 ? '0
              : in_exp == '0 ? {in_sign, (E+M)'(0)}
              : {in_sign, {E{1'b1}}, M'(0)};
    end else if (state == NORM) begin
      if (flush) begin
        result <= {sign_q, (E+M)'(0)};
        uflow <= 1'b1;
      end else begin
        mant_q <= {mant_q[M+2:0], 1'b0};
        exp_q <= exp_q - (E+2)'(1);
      end
    end else if (state == ROUND) begin
      ovf <= rovf;
      result <= rovf ? {sign_q, {E{1'b1}}, M'(0)} : {sign_q, rexp[E-1:0], rfrac};
    end
endmodule

// File: tb/tb_fpu_normround.sv
// tb_fpu_normround: directed and random checks of fpu_normround against an arithmetic model
module tb_fpu_normround;
  logic clk = 0, rst_n = 0, in_valid = 0, in_sign = 0, out_ready = 0;
  logic in_ready, out_valid, ovf, uflow;
  logic [7:0] in_exp = 0;
  logic [27:0] in_mant = 0;
  logic [31:0] result;
  int n_chk = 0, n_bad = 0;

  always #5 clk = ~clk;

  fpu_normround dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .ovf(ovf), .uflow(uflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // value = mant * 2^(exp - bias - 26); normalise by plain multiply/divide, then round half-even
  function automatic void ref_model(input logic sg, input int ex, input logic [27:0] mt,
                                    output logic [31:0] r, output bit ov, output bit uf, output int lat);
    longint m = longint'(mt);
    longint sig, grs;
    int e = ex, k = 0;
    ov = 0; uf = 0; lat = 1;
    if (m == 0) begin r = 0; return; end
    if (ex == 0) begin r = {sg, 31'b0}; uf = 1; return; end
    if (ex == 255) begin r = {sg, 8'hff, 23'b0}; return; end
    if (m >= (64'd1 << 27)) begin
      m = (m / 2) | (m % 2);
      e++;
    end else begin
      while (m < (64'd1 << 26)) begin m = m * 2; k++; end
      if (k >= ex) begin r = {sg, 31'b0}; uf = 1; lat = ex + 1; return; end
      e -= k;
    end
    lat = 2 + k;
    sig = m / 8;
    grs = m % 8;
    if (grs > 4 || (grs == 4 && sig % 2 == 1)) sig++;
    if (sig == (64'd1 << 24)) begin sig = 64'd1 << 23; e++; end
    if (e >= 255) begin r = {sg, 8'hff, 23'b0}; ov = 1; end
    else r = {sg, 8'(e), 23'(sig)};
  endfunction

  // called at posedge+1 with the DUT idle; leaves at posedge+1 with the DUT idle again
  task automatic do_op(input logic sg, input logic [7:0] ex, input logic [27:0] mt, input int hold);
    logic [31:0] er;
    bit eo, eu;
    int el, lat;
    ref_model(sg, int'(ex), mt, er, eo, eu, el);
    chk("idle_ready", 32'(in_ready), 1);
    in_valid = 1; in_sign = sg; in_exp = ex; in_mant = mt;
    @(posedge clk); #1;
    in_valid = 0; in_sign = 1'($urandom); in_exp = 8'($urandom); in_mant = 28'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("latency", lat, el);
    chk("result", result, er);
    chk("ovf", 32'(ovf), 32'(eo));
    chk("uflow", 32'(uflow), 32'(eu));
    chk("busy", 32'(in_ready), 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_result", result, er);
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_busy", 32'(in_ready), 0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_ready", 32'(in_ready), 1);
  endtask

  initial begin
    int seen;
    #2;
    chk("rst_result", result, 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_uflow", 32'(uflow), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 1);
    #10 rst_n = 1;
    @(posedge clk); #1;

    do_op(0, 127, 28'h8000000, 0);
    do_op(0, 130, 28'h1000000, 0);
    do_op(0, 127, {1'b0, 1'b1, 23'h7fffff, 3'b100}, 0);
    do_op(0, 127, {1'b0, 1'b1, 23'h000000, 3'b100}, 0);
    do_op(0, 127, {1'b0, 1'b1, 23'h000001, 3'b100}, 0);
    do_op(1, 254, 28'h8000000, 0);
    do_op(1, 100, 28'h0000000, 0);
    do_op(0, 3, 28'h0100000, 0);
    do_op(1, 0, 28'h4000000, 0);
    do_op(1, 255, 28'h4000000, 0);
    do_op(0, 127, 28'h8000000, 5);
    do_op(1, 129, 28'h4000008, 0);

    in_valid = 1; in_sign = 0; in_exp = 130; in_mant = 28'h0100000;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("midrst_result", result, 0);
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_ovf", 32'(ovf), 0);
    chk("midrst_uflow", 32'(uflow), 0);
    #2 rst_n = 1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midrst_no_out", seen, 0);
    chk("midrst_ready", 32'(in_ready), 1);

    for (int n = 0; n < 300; n++) begin
      int pos, sel;
      logic [7:0] ex;
      logic [27:0] mt;
      sel = int'($urandom_range(0, 9));
      ex = sel == 0 ? 8'd0 : sel == 1 ? 8'd255 : sel == 2 ? 8'd254
         : sel == 3 ? 8'($urandom_range(1, 6)) : 8'($urandom_range(1, 254));
      pos = int'($urandom_range(0, 27));
      mt = 28'(($urandom & ((32'd1 << (pos + 1)) - 1)) | (32'd1 << pos));
      if ($urandom_range(0, 19) == 0) mt = 0;
      if ($urandom_range(0, 7) == 0) mt[2:0] = 3'b100;
      do_op(1'($urandom), ex, mt, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
